// File: rtl/spawn_time_scheduler_if.sv
// ---------------------------------------------------------------------------
// spawn_time_scheduler_if
//   Spawn-timing ROM read port that the attack and platform streams share.
//   The scheduler drives the request side; the timing ROM answers with the
//   delay of the addressed object a fixed number of cycles later.
//
// Signals
//   rom_req    one-cycle read strobe (scheduler -> ROM)
//   rom_sel    table select, 0 = attack, 1 = platform (scheduler -> ROM)
//   rom_addr   object index low bits (scheduler -> ROM)
//   rom_delay  delay in ROM units (ROM -> scheduler)
//
// Modports
//   master  scheduler side
//   slave   ROM side
// ---------------------------------------------------------------------------
interface spawn_time_scheduler_if #(
  parameter int ROM_ADDR_W = 10
);
  logic                  rom_req;
  logic                  rom_sel;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [15:0]           rom_delay;

  modport master (
    output rom_req,
    output rom_sel,
    output rom_addr,
    input  rom_delay
  );

  modport slave (
    input  rom_req,
    input  rom_sel,
    input  rom_addr,
    output rom_delay
  );
endinterface

// File: rtl/spawn_time_scheduler.sv
// ---------------------------------------------------------------------------
// spawn_time_scheduler
//   Works out the next spawn time for the attack and platform streams of
//   game_runtime. A stream asks for a new time by pulling its sync line low.
//   The block picks one stream, reads that object's delay through the shared
//   timing ROM port, adds delay*TIME_SCALE to the current time (saturating),
//   and pulses the matching update line.
//
// Ports
//   clk                   system clock
//   reset_n               asynchronous active-low reset
//   current_time          runtime clock in centiseconds
//   sync_attack_time      low = attack stream requests a new time
//   sync_platform_time    low = platform stream requests a new time
//   attack_i              attack object index
//   platform_i            platform object index
//   is_reset_stage        stage flush: aborts an in-flight lookup, blocks grants
//   rom                   shared timing ROM port (master side)
//   next_attack_time      scheduled attack spawn time
//   next_platform_time    scheduled platform spawn time
//   update_attack_time    one-cycle pulse, next_attack_time written
//   update_platform_time  one-cycle pulse, next_platform_time written
//   busy                  high whenever a lookup is in progress
//
// Configuration
//   SPAWN_ATTACK_PRIORITY_EN  defined: attack always wins a tie.
//                             undefined (default): round-robin between streams.
// ---------------------------------------------------------------------------
module spawn_time_scheduler #(
  parameter int MAXIMUM_TIMES           = 30,
  parameter int MAXIMUM_ATTACK_OBJECT   = 20,
  parameter int MAXIMUM_PLATFORM_OBJECT = 20,
  parameter int ROM_ADDR_W              = 10,
  parameter int ROM_LATENCY             = 2,
  parameter int TIME_SCALE              = 10
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [MAXIMUM_TIMES-1:0]           current_time,
  input  logic                               sync_attack_time,
  input  logic                               sync_platform_time,
  input  logic [MAXIMUM_ATTACK_OBJECT-1:0]   attack_i,
  input  logic [MAXIMUM_PLATFORM_OBJECT-1:0] platform_i,
  input  logic                               is_reset_stage,
  spawn_time_scheduler_if.master             rom,
  output logic [MAXIMUM_TIMES-1:0]           next_attack_time,
  output logic [MAXIMUM_TIMES-1:0]           next_platform_time,
  output logic                               update_attack_time,
  output logic                               update_platform_time,
  output logic                               busy
);

  localparam int CNT_W  = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam int WIDE_W = MAXIMUM_TIMES + 8;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(ROM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    CALC
  } state_t;

  state_t                   state;
  logic                     served_attack;
  logic                     served_platform;
  logic                     grant_platform;
  logic [MAXIMUM_TIMES-1:0] base_time;
  logic [15:0]              delay_q;
  logic [CNT_W-1:0]         wait_cnt;
`ifndef SPAWN_ATTACK_PRIORITY_EN
  logic                     last_grant;
`endif

  logic                     pending_attack;
  logic                     pending_platform;
  logic                     pick_platform;
  logic [WIDE_W-1:0]        sum_wide;
  logic [MAXIMUM_TIMES-1:0] sat_time;

  // Only the low index bits address the ROM; the upper bits are deliberately dropped.
  logic unused_index_bits;
  assign unused_index_bits = ^{attack_i[MAXIMUM_ATTACK_OBJECT-1:ROM_ADDR_W],
                               platform_i[MAXIMUM_PLATFORM_OBJECT-1:ROM_ADDR_W]};

  // A stream is pending while its sync line is low, it has not yet been served
  // for this request, and no stage flush is in progress.
  always_comb begin
    pending_attack   = !sync_attack_time && !served_attack && !is_reset_stage;
    pending_platform = !sync_platform_time && !served_platform && !is_reset_stage;
    pick_platform    = 1'b0;
`ifdef SPAWN_ATTACK_PRIORITY_EN
    pick_platform = !pending_attack;
`else
    if (pending_attack && pending_platform) begin
      pick_platform = !last_grant;
    end else begin
      pick_platform = !pending_attack;
    end
`endif
  end

  // Spawn time = latched base + delay * scale, computed wide enough to see
  // any carry out of the time width, then clamped to all-ones.
  always_comb begin
    sum_wide = WIDE_W'(base_time) + WIDE_W'(delay_q) * WIDE_W'(TIME_SCALE);
    sat_time = sum_wide[MAXIMUM_TIMES-1:0];
    if (|sum_wide[WIDE_W-1:MAXIMUM_TIMES]) begin
      sat_time = '1;
    end
  end

  // Lookup FSM with all outputs registered. rom_sel/rom_addr are only loaded
  // on a grant so the ROM never sees them change outside a request. Setting
  // the served flag together with the update pulse stops the still-low sync
  // line from being granted again in the IDLE cycle that follows.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      served_attack        <= 1'b0;
      served_platform      <= 1'b0;
      grant_platform       <= 1'b0;
      base_time            <= '0;
      delay_q              <= '0;
      wait_cnt             <= '0;
      rom.rom_req          <= 1'b0;
      rom.rom_sel          <= 1'b0;
      rom.rom_addr         <= '0;
      next_attack_time     <= '0;
      next_platform_time   <= '0;
      update_attack_time   <= 1'b0;
      update_platform_time <= 1'b0;
      busy                 <= 1'b0;
`ifndef SPAWN_ATTACK_PRIORITY_EN
      last_grant           <= 1'b1;
`endif
    end else begin
      update_attack_time   <= 1'b0;
      update_platform_time <= 1'b0;
      rom.rom_req          <= 1'b0;

      if (sync_attack_time) begin
        served_attack <= 1'b0;
      end
      if (sync_platform_time) begin
        served_platform <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pending_attack || pending_platform) begin
            grant_platform <= pick_platform;
`ifndef SPAWN_ATTACK_PRIORITY_EN
            last_grant     <= pick_platform;
`endif
            rom.rom_req    <= 1'b1;
            rom.rom_sel    <= pick_platform;
            rom.rom_addr   <= pick_platform ? platform_i[ROM_ADDR_W-1:0]
                                            : attack_i[ROM_ADDR_W-1:0];
            busy           <= 1'b1;
            state          <= ISSUE;
          end
        end

        ISSUE: begin
          if (is_reset_stage) begin
            served_attack   <= 1'b0;
            served_platform <= 1'b0;
            busy            <= 1'b0;
            state           <= IDLE;
          end else begin
            base_time <= current_time;
            wait_cnt  <= WAIT_INIT;
            state     <= WAIT;
          end
        end

        WAIT: begin
          if (is_reset_stage) begin
            served_attack   <= 1'b0;
            served_platform <= 1'b0;
            busy            <= 1'b0;
            state           <= IDLE;
          end else if (wait_cnt == '0) begin
            delay_q <= rom.rom_delay;
            state   <= CALC;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        CALC: begin
          if (is_reset_stage) begin
            served_attack   <= 1'b0;
            served_platform <= 1'b0;
          end else if (grant_platform) begin
            next_platform_time   <= sat_time;
            update_platform_time <= 1'b1;
            served_platform      <= 1'b1;
          end else begin
            next_attack_time   <= sat_time;
            update_attack_time <= 1'b1;
            served_attack      <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spawn_time_scheduler.sv
// ---------------------------------------------------------------------------
// tb_spawn_time_scheduler
//   Directed bench for spawn_time_scheduler with ROM_LATENCY=2, TIME_SCALE=10.
//   The ROM is modelled by driving rom_delay directly for each lookup.
// ---------------------------------------------------------------------------
module tb_spawn_time_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [29:0] current_time;
  logic        sync_attack_time;
  logic        sync_platform_time;
  logic [19:0] attack_i;
  logic [19:0] platform_i;
  logic        is_reset_stage;
  logic [29:0] next_attack_time;
  logic [29:0] next_platform_time;
  logic        update_attack_time;
  logic        update_platform_time;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int rom_reads    = 0;
  int upd_a_count  = 0;

  spawn_time_scheduler_if #(.ROM_ADDR_W(10)) rom_bus ();

  spawn_time_scheduler #(
    .MAXIMUM_TIMES          (30),
    .MAXIMUM_ATTACK_OBJECT  (20),
    .MAXIMUM_PLATFORM_OBJECT(20),
    .ROM_ADDR_W             (10),
    .ROM_LATENCY            (2),
    .TIME_SCALE             (10)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .current_time        (current_time),
    .sync_attack_time    (sync_attack_time),
    .sync_platform_time  (sync_platform_time),
    .attack_i            (attack_i),
    .platform_i          (platform_i),
    .is_reset_stage      (is_reset_stage),
    .rom                 (rom_bus),
    .next_attack_time    (next_attack_time),
    .next_platform_time  (next_platform_time),
    .update_attack_time  (update_attack_time),
    .update_platform_time(update_platform_time),
    .busy                (busy)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Count ROM strobes and attack update pulses as they happen.
  always @(posedge clk) begin
    if (rom_bus.rom_req) rom_reads <= rom_reads + 1;
    if (update_attack_time) upd_a_count <= upd_a_count + 1;
  end

  // One comparison: counts it, and on mismatch counts a failure and reports.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Change the sync lines on the next falling edge.
  task automatic applyStimulus(input logic sa, input logic sp);
    @(negedge clk);
    sync_attack_time   = sa;
    sync_platform_time = sp;
  endtask

  // Called on the falling edge right after the granting edge. Checks the ROM
  // strobe, waits (bounded) for the update pulse and checks latency/result.
  task automatic serviceCheck(input string tag, input logic exp_sel,
                              input logic [9:0] exp_addr, input logic [15:0] delay,
                              input logic [29:0] exp_time);
    int  n;
    bit  seen;
    rom_bus.rom_delay = delay;
    checkOutput({tag, " rom_req"}, rom_bus.rom_req, 1);
    checkOutput({tag, " rom_sel"}, rom_bus.rom_sel, exp_sel);
    checkOutput({tag, " rom_addr"}, rom_bus.rom_addr, exp_addr);
    checkOutput({tag, " busy"}, busy, 1);
    n    = 0;
    seen = 0;
    while (n < 10 && !seen) begin
      @(negedge clk);
      n++;
      if (update_attack_time || update_platform_time) seen = 1;
    end
    checkOutput({tag, " latency"}, n, 4);
    checkOutput({tag, " upd_attack"}, update_attack_time, !exp_sel);
    checkOutput({tag, " upd_platform"}, update_platform_time, exp_sel);
    checkOutput({tag, " rom_addr hold"}, rom_bus.rom_addr, exp_addr);
    if (exp_sel) checkOutput({tag, " next_platform"}, next_platform_time, exp_time);
    else         checkOutput({tag, " next_attack"}, next_attack_time, exp_time);
  endtask

  initial begin
    int reads_before;
    int upd_before;

    reset_n            = 1'b0;
    sync_attack_time   = 1'b1;
    sync_platform_time = 1'b1;
    is_reset_stage     = 1'b0;
    current_time       = 30'd100;
    attack_i           = 20'd3;
    platform_i         = 20'd7;
    rom_bus.rom_delay  = 16'd0;

    // Reset state
    #2;
    checkOutput("reset next_attack", next_attack_time, 0);
    checkOutput("reset next_platform", next_platform_time, 0);
    checkOutput("reset upd_attack", update_attack_time, 0);
    checkOutput("reset upd_platform", update_platform_time, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset rom_req", rom_bus.rom_req, 0);
    checkOutput("reset rom_sel", rom_bus.rom_sel, 0);
    checkOutput("reset rom_addr", rom_bus.rom_addr, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single attack request: 100 + 5*10 = 150
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    serviceCheck("t1 attack", 1'b0, 10'd3, 16'd5, 30'd150);
    sync_attack_time = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t1 idle busy", busy, 0);

    // Joint requests after a fresh reset
    reset_n = 1'b0;
    @(negedge clk);
    reset_n      = 1'b1;
    current_time = 30'd200;
    attack_i     = 20'd11;
    platform_i   = 20'd22;
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    serviceCheck("t2 joint attack", 1'b0, 10'd11, 16'd1, 30'd210);
    sync_attack_time = 1'b1;
    @(negedge clk);
    serviceCheck("t2 joint platform", 1'b1, 10'd22, 16'd3, 30'd230);
    sync_platform_time = 1'b1;
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    serviceCheck("t2 lone attack", 1'b0, 10'd11, 16'd2, 30'd220);
    sync_attack_time = 1'b1;
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
`ifdef SPAWN_ATTACK_PRIORITY_EN
    serviceCheck("t2 second joint attack", 1'b0, 10'd11, 16'd4, 30'd240);
    sync_attack_time = 1'b1;
    @(negedge clk);
    serviceCheck("t2 second joint platform", 1'b1, 10'd22, 16'd6, 30'd260);
    sync_platform_time = 1'b1;
`else
    serviceCheck("t2 second joint platform", 1'b1, 10'd22, 16'd6, 30'd260);
    sync_platform_time = 1'b1;
    @(negedge clk);
    serviceCheck("t2 second joint attack", 1'b0, 10'd11, 16'd4, 30'd240);
    sync_attack_time = 1'b1;
`endif

    // Sync held low after service: no second read until it toggles
    current_time = 30'd300;
    @(negedge clk);
    reads_before = rom_reads;
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    serviceCheck("t3 first", 1'b0, 10'd11, 16'd5, 30'd350);
    repeat (3) @(negedge clk);
    checkOutput("t3 single read", rom_reads, reads_before + 1);
    checkOutput("t3 held busy", busy, 0);
    sync_attack_time = 1'b1;
    @(negedge clk);
    sync_attack_time = 1'b0;
    @(negedge clk);
    serviceCheck("t3 reread", 1'b0, 10'd11, 16'd5, 30'd350);
    checkOutput("t3 second read", rom_reads, reads_before + 2);
    sync_attack_time = 1'b1;

    // Saturation and width boundaries
    current_time = 30'h3FFFFFEC;
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    serviceCheck("t4 saturate", 1'b0, 10'd11, 16'd5, 30'h3FFFFFFF);
    sync_attack_time = 1'b1;
    current_time = 30'h3FFFFFCE;
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    serviceCheck("t4 carry exactly", 1'b0, 10'd11, 16'd5, 30'h3FFFFFFF);
    sync_attack_time = 1'b1;
    current_time = 30'h3FFFFFCC;
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    serviceCheck("t4 no saturate", 1'b1, 10'd22, 16'd5, 30'h3FFFFFFE);
    sync_platform_time = 1'b1;
    current_time = 30'd1000;
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    serviceCheck("t4 max delay", 1'b1, 10'd22, 16'hFFFF, 30'd656350);
    sync_platform_time = 1'b1;
    current_time = 30'd500;
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    serviceCheck("t4 zero delay", 1'b0, 10'd11, 16'd0, 30'd500);
    sync_attack_time = 1'b1;

    // Stage flush during WAIT
    current_time = 30'd600;
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    rom_bus.rom_delay = 16'd9;
    @(negedge clk);
    is_reset_stage = 1'b1;
    @(negedge clk);
    checkOutput("t5 abort busy", busy, 0);
    checkOutput("t5 abort upd", update_attack_time, 0);
    is_reset_stage   = 1'b0;
    sync_attack_time = 1'b1;
    upd_before       = upd_a_count;
    repeat (6) @(negedge clk);
    checkOutput("t5 no pulse", upd_a_count, upd_before);
    checkOutput("t5 next_attack kept", next_attack_time, 500);
    checkOutput("t5 idle busy", busy, 0);

    // Asynchronous reset in the middle of WAIT
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t6 next_attack", next_attack_time, 0);
    checkOutput("t6 next_platform", next_platform_time, 0);
    checkOutput("t6 busy", busy, 0);
    checkOutput("t6 rom_addr", rom_bus.rom_addr, 0);
    checkOutput("t6 rom_sel", rom_bus.rom_sel, 0);
    checkOutput("t6 rom_req", rom_bus.rom_req, 0);
    @(negedge clk);
    sync_attack_time = 1'b1;
    reset_n          = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
